regfile_watch_monitor: RTL



---
 rtl/regfile_watch_monitor_if.sv | 43 ++++
 rtl/regfile_watch_monitor.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/regfile_watch_monitor_if.sv
// Bus bundle between the core-side driver and regfile_watch_monitor:
// configuration, write-back snoop, status and change-log signals.
interface regfile_watch_monitor_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_WATCH = 3,
  parameter int unsigned IDXW      = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1
);
  logic                      start;
  logic                      cfg_we;
  logic [IDXW-1:0]           cfg_idx;
  logic [4:0]                cfg_addr;
  logic [XLEN-1:0]           cfg_exp;
  logic                      wb_en;
  logic [4:0]                wb_addr;
  logic [XLEN-1:0]           wb_data;
  logic [NUM_WATCH*XLEN-1:0] shadow_data;
  logic [NUM_WATCH-1:0]      match_vec;
  logic                      chg_valid;
  logic [IDXW-1:0]           chg_idx;
  logic [XLEN-1:0]           chg_data;
  logic                      busy;
  logic                      pass;
  logic                      fail;
  logic [31:0]               cycle_cnt;
  logic                      log_pop;
  logic                      log_valid;
  logic [IDXW-1:0]           log_idx;
  logic [XLEN-1:0]           log_data;

  modport master (
    output start, cfg_we, cfg_idx, cfg_addr, cfg_exp,
    output wb_en, wb_addr, wb_data, log_pop,
    input  shadow_data, match_vec, chg_valid, chg_idx, chg_data,
    input  busy, pass, fail, cycle_cnt, log_valid, log_idx, log_data
  );

  modport slave (
    input  start, cfg_we, cfg_idx, cfg_addr, cfg_exp,
    input  wb_en, wb_addr, wb_data, log_pop,
    output shadow_data, match_vec, chg_valid, chg_idx, chg_data,
    output busy, pass, fail, cycle_cnt, log_valid, log_idx, log_data
  );
endinterface

// File: rtl/regfile_watch_monitor.sv
// Shadows NUM_WATCH architectural registers from the write-back port and flags PASS/FAIL.
// Optional change-log FIFO enabled by defining REGFILE_WATCH_LOG_EN.
module regfile_watch_monitor #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_WATCH = 3,
  parameter int unsigned TIMEOUT   = 4096,
  parameter int unsigned LOG_DEPTH = 8,
  parameter int unsigned IDXW      = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1
) (
  input logic                    clk,
  input logic                    rst,
  regfile_watch_monitor_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_e;

  state_e               state_q, state_d;
  logic [4:0]           cfg_addr_q [NUM_WATCH];
  logic [XLEN-1:0]      cfg_exp_q  [NUM_WATCH];
  logic [XLEN-1:0]      shadow_q   [NUM_WATCH];
  logic [XLEN-1:0]      shadow_d   [NUM_WATCH];
  logic [31:0]          cnt_q, cnt_d;
  logic                 chg_valid_q, chg_valid_d;
  logic [IDXW-1:0]      chg_idx_q, chg_idx_d;
  logic [XLEN-1:0]      chg_data_q, chg_data_d;
  logic                 busy_q, pass_q, fail_q;
  logic [NUM_WATCH-1:0] match_c;
  logic [NUM_WATCH-1:0] changed_c;
  logic                 start_run_c;

  assign start_run_c = bus.start && (state_q != S_RUN);

  for (genvar g = 0; g < NUM_WATCH; g++) begin : g_chan
    assign match_c[g] = (shadow_q[g] == cfg_exp_q[g]);
    assign bus.shadow_data[g*XLEN +: XLEN] = shadow_q[g];
  end

  // Next-state, shadow update and change detection
  always_comb begin
    logic found;
    state_d     = state_q;
    shadow_d    = shadow_q;
    cnt_d       = cnt_q;
    chg_valid_d = 1'b0;
    chg_idx_d   = chg_idx_q;
    chg_data_d  = chg_data_q;
    changed_c   = '0;
    found       = 1'b0;
    case (state_q)
      S_RUN: begin
        if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
        for (int unsigned i = 0; i < NUM_WATCH; i++) begin
          if (bus.wb_en && (bus.wb_addr != 5'd0) && (bus.wb_addr == cfg_addr_q[i])) begin
            shadow_d[i]  = bus.wb_data;
            changed_c[i] = (bus.wb_data != shadow_q[i]);
          end
        end
        for (int unsigned i = 0; i < NUM_WATCH; i++) begin
          if (changed_c[i] && !found) begin
            found     = 1'b1;
            chg_idx_d = IDXW'(i);
          end
        end
        if (found) begin
          chg_valid_d = 1'b1;
          chg_data_d  = bus.wb_data;
        end
        // PASS takes priority over a coincident timeout
        if (&match_c)                        state_d = S_PASS;
        else if (cnt_q == 32'(TIMEOUT - 1))  state_d = S_FAIL;
      end
      default: begin
        if (bus.start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          for (int unsigned i = 0; i < NUM_WATCH; i++) shadow_d[i] = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      chg_valid_q <= 1'b0;
      chg_idx_q   <= '0;
      chg_data_q  <= '0;
      busy_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      for (int unsigned i = 0; i < NUM_WATCH; i++) shadow_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      chg_valid_q <= chg_valid_d;
      chg_idx_q   <= chg_idx_d;
      chg_data_q  <= chg_data_d;
      busy_q      <= (state_d == S_RUN);
      pass_q      <= (state_d == S_PASS);
      fail_q      <= (state_d == S_FAIL);
      shadow_q    <= shadow_d;
    end
  end

  // Channel configuration is frozen while a run is in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_WATCH; i++) begin
        cfg_addr_q[i] <= '0;
        cfg_exp_q[i]  <= '0;
      end
    end else if (bus.cfg_we && (state_q != S_RUN)) begin
      for (int unsigned i = 0; i < NUM_WATCH; i++) begin
        if (bus.cfg_idx == IDXW'(i)) begin
          cfg_addr_q[i] <= bus.cfg_addr;
          cfg_exp_q[i]  <= bus.cfg_exp;
        end
      end
    end
  end

  assign bus.match_vec = match_c;
  assign bus.chg_valid = chg_valid_q;
  assign bus.chg_idx   = chg_idx_q;
  assign bus.chg_data  = chg_data_q;
  assign bus.busy      = busy_q;
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.cycle_cnt = cnt_q;

`ifdef REGFILE_WATCH_LOG_EN
  localparam int unsigned LOGW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
  localparam int unsigned CNTW = LOGW + 1;

  logic [IDXW-1:0] log_idx_mem  [LOG_DEPTH];
  logic [XLEN-1:0] log_data_mem [LOG_DEPTH];
  logic [LOGW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q;
  logic            push_c, pop_c, full_c;

  assign full_c = (count_q == CNTW'(LOG_DEPTH));
  assign pop_c  = bus.log_pop && (count_q != '0);
  // A pop in the same cycle frees the slot, so a full log still accepts the event
  assign push_c = chg_valid_d && (!full_c || pop_c);

  always_ff @(posedge clk) begin
    if (rst || start_run_c) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= (wr_ptr_q == LOGW'(LOG_DEPTH - 1)) ? '0 : wr_ptr_q + LOGW'(1);
      if (pop_c)  rd_ptr_q <= (rd_ptr_q == LOGW'(LOG_DEPTH - 1)) ? '0 : rd_ptr_q + LOGW'(1);
      if (push_c && !pop_c)      count_q <= count_q + CNTW'(1);
      else if (pop_c && !push_c) count_q <= count_q - CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      log_idx_mem[wr_ptr_q]  <= chg_idx_d;
      log_data_mem[wr_ptr_q] <= chg_data_d;
    end
  end

  assign bus.log_valid = (count_q != '0);
  assign bus.log_idx   = (count_q != '0) ? log_idx_mem[rd_ptr_q]  : '0;
  assign bus.log_data  = (count_q != '0) ? log_data_mem[rd_ptr_q] : '0;
`else
  logic unused_log;
  assign unused_log    = ^{bus.log_pop, start_run_c, 32'(LOG_DEPTH)};
  assign bus.log_valid = 1'b0;
  assign bus.log_idx   = '0;
  assign bus.log_data  = '0;
`endif

endmodule
